uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sets the number of enable pulses per serial bit; legal values are 2..256.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 enable  input  1  baud tick from the baud rate generator; one-cycle pulse, OVERSAMPLE pulses per bit.
REQ-005 iocs  input  1  chip select for processor bus accesses.
REQ-006 iorw  input  1  bus direction; 0 = write, 1 = read.
REQ-007 ioaddr  input  2  register address; 2'b00 = transmit buffer.
REQ-008 data_bus  input  8  write data byte.
REQ-009 tbr  output  1  transmit buffer ready; 1 = holding register empty and a write is accepted.
REQ-010 txd  output  1  serial output line; idle high.

Function
REQ-011 The write strobe SHALL be iocs=1, iorw=0, ioaddr=2'b00, asserted for one clk cycle.
REQ-012 When the write strobe is asserted and tbr=1, data_bus SHALL be captured into an 8-bit holding register, and tbr SHALL be 0 from the next cycle.
REQ-013 When the write strobe is asserted and tbr=0, the write SHALL be ignored; holding register contents and tbr SHALL remain unchanged.
REQ-014 The block SHALL implement four states: IDLE, START, DATA and STOP.
REQ-015 In IDLE with the holding register full, on the next edge the block SHALL copy the holding register to the shift register, set tbr=1, clear the tick and bit counters, and enter START.
REQ-016 The tick counter SHALL increment only on cycles where enable=1.
REQ-017 A bit period SHALL end on the enable pulse where tick count = OVERSAMPLE-1; the counter then wraps to 0.
REQ-018 txd SHALL be 1 in IDLE and 0 in START.
REQ-019 In DATA, txd SHALL equal shift register bit 0.
REQ-020 txd SHALL be 1 in STOP.
REQ-021 txd SHALL be registered and change only on the edge entering a state or a new data bit.
REQ-022 At the end of START, the block SHALL enter DATA with bit count 0.
REQ-023 At the end of each DATA bit, the shift register SHALL shift right by one and the bit count SHALL increment; data is sent LSB first.
REQ-024 After the 8th data bit, the block SHALL enter STOP.
REQ-025 At the end of STOP, the block SHALL enter IDLE.
REQ-026 A complete frame SHALL occupy exactly 10*OVERSAMPLE enable pulses.
REQ-027 Consecutive frames SHALL be separated by at least one clk cycle spent in IDLE.
REQ-028 Because of double buffering, a byte written during START, DATA or STOP SHALL be held and transmitted immediately after the current frame.
REQ-029 enable pulses in IDLE SHALL have no effect.
REQ-030 Writes and an IDLE->START transfer cannot coincide, since a transfer needs a full holding register and a write needs tbr=1; no priority rule is needed.
REQ-031 Bus reads (iorw=1) and accesses with ioaddr other than 2'b00 SHALL be ignored by this block.
REQ-032 With enable held high continuously, each bit SHALL last OVERSAMPLE clk cycles.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL enter IDLE and set txd=1 and tbr=1.
REQ-034 Reset SHALL clear the holding-register-full flag, the tick counter and the bit counter.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately (txd=1 on the next cycle); the pending holding byte SHALL be discarded and never transmitted.
REQ-036 A write strobe in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-037 After reset, with no writes -> txd=1 and tbr=1 held for 1000 cycles, independent of enable activity.
REQ-038 Write 8'hA5, enable every cycle, OVERSAMPLE=16 -> txd shows 0,1,0,1,0,0,1,0,1,1 at 16 cycles per bit; tbr=0 for exactly one cycle after the write.
REQ-039 Write 8'h3C, then write 8'hC3 during the first data bit -> second write accepted (tbr 1->0); 8'h3C frame followed by 8'hC3 frame with 1 idle cycle between stop bit and start bit.
REQ-040 While the holding register is full, write 8'hFF -> write ignored; the frame transmitted carries the earlier byte.
REQ-041 Enable pulsed once every 5 cycles -> each bit lasts 80 clk cycles; frame length 800 cycles.
REQ-042 Assert rst during data bit 3 of a frame with a second byte pending -> txd=1 and tbr=1 on the next cycle; no further frame begins without a new write.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one holding register plus one shift register (double buffered), 8N1 framing.
// Latency: a byte written while idle starts its start bit two clk edges after the write.
// Backpressure: tbr=0 while the holding register is full; writes made then are dropped.
module uart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] data_bus,
  output logic       tbr,
  output logic       txd
);

  // Tick counter spans 0..OVERSAMPLE-1; OVERSAMPLE=2 still needs one bit.
  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    hold_reg;
  logic [7:0]    hold_nxt;
  logic          hold_full;
  logic          hold_full_nxt;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_nxt;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic          txd_nxt;
  logic          wr_stb;
  logic          bit_end;

  // Only a write to address 0 is ours; reads and other addresses are left alone.
  assign wr_stb  = iocs & ~iorw & (ioaddr == 2'b00);
  // A serial bit finishes on the enable pulse that sees the last tick value.
  assign bit_end = enable & (tick_cnt == TICK_LAST);
  // The holding register is the only buffer the bus sees.
  assign tbr     = ~hold_full;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath updates and the registered line value for the next cycle.
  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_reg;
    hold_full_nxt = hold_full;
    shift_nxt     = shift_reg;
    tick_nxt      = tick_cnt;
    bit_nxt       = bit_cnt;
    txd_nxt       = txd;

    // A write needs an empty holding register, so it never collides with the
    // IDLE transfer below, which needs a full one.
    if (wr_stb && !hold_full) begin
      hold_nxt      = data_bus;
      hold_full_nxt = 1'b1;
    end

    // Baud ticks only advance the bit timer while a frame is on the line.
    if (state != IDLE && enable) begin
      tick_nxt = bit_end ? '0 : tick_cnt + TW'(1);
    end

    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (hold_full) begin
          shift_nxt     = hold_reg;
          hold_full_nxt = 1'b0;
          tick_nxt      = '0;
          bit_nxt       = '0;
          txd_nxt       = 1'b0;
          state_nxt     = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_nxt   = '0;
          txd_nxt   = shift_reg[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = {1'b0, shift_reg[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            txd_nxt   = 1'b1;
            state_nxt = STOP;
          end else begin
            txd_nxt   = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          txd_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers; reset drops any pending byte and forces the line idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      txd       <= 1'b1;
    end else begin
      hold_reg  <= hold_nxt;
      hold_full <= hold_full_nxt;
      shift_reg <= shift_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      txd       <= txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed writes; expected frames go into a queue and a
// line monitor decodes txd from a per-cycle history and checks each frame.
module tb_uart_tx;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] data_bus;
  logic       tbr;
  logic       txd;

  uart_tx #(.OVERSAMPLE(OS)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .data_bus (data_bus),
    .tbr      (tbr),
    .txd      (txd)
  );

  typedef struct {
    logic [7:0] dat;
    int         blen;
    bit         exact;
    int         slack;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   frames_done = 0;
  int   frames_exp = 0;
  bit   hist [0:99999];
  bit   mon_en = 1'b0;
  bit   en_on = 1'b0;
  int   div = 1;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // txd history, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (cyc < 100000) hist[cyc] = txd;
  end

  // Baud tick source: one pulse every 'div' cycles
  initial begin
    int ecnt;
    ecnt = 0;
    enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ecnt >= div - 1) ecnt = 0;
      else ecnt++;
      enable = en_on && (ecnt == 0);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Frame monitor
  initial begin : monitor
    int         p;
    int         last_end;
    int         c0;
    int         t1;
    bit         ok_t;
    bit         expb;
    logic [7:0] rx;
    exp_t       e;
    p = 0;
    last_end = -100000;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        p = cyc;
        continue;
      end
      while (p < cyc && hist[p] == 1'b1) p++;
      if (p < cyc) begin
        c0 = p;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_start", c0, -1);
          p = c0 + 10 * OS;
          continue;
        end
        e = exp_q.pop_front();
        while (cyc <= c0 + 10 * e.blen + 1 && mon_en) @(negedge clk);
        if (!mon_en) begin
          p = cyc;
          continue;
        end
        ok_t = 1'b1;
        t1 = -1;
        if (e.exact) begin
          t1 = c0 + e.blen;
          for (int i = c0; i < t1; i++) if (hist[i] != 1'b0) ok_t = 1'b0;
        end else begin
          for (int i = c0 + 1; i <= c0 + e.blen; i++) if (t1 < 0 && hist[i] == 1'b1) t1 = i;
          if (t1 < 0) begin
            ok_t = 1'b0;
            t1 = c0 + e.blen;
          end else if (t1 - c0 < e.blen - e.slack) begin
            ok_t = 1'b0;
          end
        end
        for (int j = 0; j < 9; j++) begin
          expb = (j == 8) ? 1'b1 : e.dat[j];
          for (int i = 0; i < e.blen; i++) if (hist[t1 + j * e.blen + i] != expb) ok_t = 1'b0;
        end
        for (int j = 0; j < 8; j++) rx[j] = hist[t1 + j * e.blen + e.blen / 2];
        chk("frame_data", int'(rx), int'(e.dat));
        chk("frame_timing", int'(ok_t), 1);
        if (e.gap >= 0) chk("frame_gap", c0 - last_end, e.gap);
        last_end = t1 + 9 * e.blen;
        p = last_end;
        frames_done++;
      end
    end
  end

  task automatic push(input logic [7:0] d, input int blen, input bit exact, input int slack, input int gap);
    exp_t e;
    e.dat = d;
    e.blen = blen;
    e.exact = exact;
    e.slack = slack;
    e.gap = gap;
    exp_q.push_back(e);
    frames_exp++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    iocs = cs;
    iorw = rw;
    ioaddr = a;
    data_bus = d;
    @(posedge clk);
    #1;
    iocs = 1'b0;
    iorw = 1'b0;
    ioaddr = 2'b00;
  endtask

  task automatic wr(input logic [7:0] d);
    bus(1'b1, 1'b0, 2'b00, d);
  endtask

  task automatic wait_frames(input int budget);
    int k;
    k = 0;
    while (frames_done < frames_exp && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("frames_done", frames_done, frames_exp);
  endtask

  task automatic idle_hold(input string name, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1 || tbr !== 1'b1) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    iocs = 1'b0;
    iorw = 1'b0;
    ioaddr = 2'b00;
    data_bus = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tbr", int'(tbr), 1);
    chk("reset_txd", int'(txd), 1);

    // Idle with baud ticks running and no writes
    en_on = 1'b1;
    div = 3;
    mon_en = 1'b1;
    idle_hold("idle_1000", 1000);

    // Single byte, enable every cycle, tbr low for one cycle
    div = 1;
    tick(4);
    @(negedge clk);
    chk("a5_tbr_pre", int'(tbr), 1);
    push(8'hA5, OS, 1'b1, 0, -1);
    wr(8'hA5);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (tbr === 1'b0) n++;
    end
    chk("a5_tbr_low_cycles", n, 1);
    wait_frames(400);

    // Second byte written during first data bit goes out right after
    tick(5);
    push(8'h3C, OS, 1'b1, 0, -1);
    push(8'hC3, OS, 1'b1, 0, 1);
    wr(8'h3C);
    tick(21);
    @(negedge clk);
    chk("c3_tbr_pre", int'(tbr), 1);
    wr(8'hC3);
    @(negedge clk);
    chk("c3_tbr_accept", int'(tbr), 0);
    wait_frames(600);

    // Write while holding register full is dropped
    tick(5);
    push(8'h5A, OS, 1'b1, 0, -1);
    push(8'h96, OS, 1'b1, 0, 1);
    wr(8'h5A);
    tick(3);
    wr(8'h96);
    @(negedge clk);
    chk("ff_tbr_full", int'(tbr), 0);
    wr(8'hFF);
    @(negedge clk);
    chk("ff_tbr_still_full", int'(tbr), 0);
    wait_frames(600);

    // Reads, other addresses and a write during reset are ignored
    tick(5);
    bus(1'b1, 1'b1, 2'b00, 8'h11);
    bus(1'b1, 1'b0, 2'b01, 8'h22);
    bus(1'b1, 1'b0, 2'b10, 8'h33);
    bus(1'b1, 1'b0, 2'b11, 8'h44);
    @(negedge clk);
    chk("ignored_access_tbr", int'(tbr), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    iocs = 1'b1;
    iorw = 1'b0;
    ioaddr = 2'b00;
    data_bus = 8'h77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    iocs = 1'b0;
    @(negedge clk);
    chk("rst_write_tbr", int'(tbr), 1);
    idle_hold("ignored_idle", 200);

    // Enable every 5 cycles: 80-cycle bits
    div = 5;
    tick(7);
    push(8'h55, 5 * OS, 1'b0, 4, -1);
    wr(8'h55);
    wait_frames(2000);

    // Reset in data bit 3 with a byte pending
    div = 1;
    tick(5);
    mon_en = 1'b0;
    wr(8'h0F);
    tick(3);
    wr(8'hF0);
    tick(60);
    @(negedge clk);
    chk("abort_pending_tbr", int'(tbr), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_txd", int'(txd), 1);
    chk("abort_tbr", int'(tbr), 1);
    idle_hold("abort_no_frame", 400);
    mon_en = 1'b1;

    // Block still transmits after the abort
    tick(3);
    push(8'h81, OS, 1'b1, 0, -1);
    wr(8'h81);
    wait_frames(400);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
